// File: rtl/data_mem_pkg.sv
// Shared sizing constants for the MIPS data memory.
package data_mem_pkg;

    parameter int unsigned DATA_W    = 32;
    parameter int unsigned DEPTH     = 3072;
    parameter logic [31:0] MEM_BYTES = 32'h3000;
    parameter int unsigned IDX_W     = 12;

    // True when the byte address maps onto an existing word.
    function automatic logic word_in_range(input logic [31:0] addr);
        return addr < MEM_BYTES;
    endfunction

endpackage

// File: rtl/data_memory.sv
// Word-addressed data memory: synchronous write, combinational read, async clear.
// Optional macro DATA_MEM_ALIGN_CHECK_EN rejects accesses with addr[1:0] != 0.
module data_memory
    import data_mem_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              memwrite,
    input  logic              memread,
    input  logic [31:0]       addr,
    input  logic [DATA_W-1:0] write_d,
    output logic [DATA_W-1:0] read_d
);

    logic [DATA_W-1:0] d_mem [0:DEPTH-1];

    logic [IDX_W-1:0] idx;
    logic             in_range;
    logic             aligned;
    logic             access_ok;
    logic             wr_en;

`ifdef DATA_MEM_ALIGN_CHECK_EN
    assign aligned = (addr[1:0] == 2'b00);
`else
    // Low bits are deliberately dropped; this keeps them visibly consumed.
    logic unused_addr_lo;
    assign unused_addr_lo = ^addr[1:0];
    assign aligned        = 1'b1;
`endif

    always_comb begin
        idx       = addr[IDX_W+1:2];
        in_range  = word_in_range(addr);
        access_ok = in_range && aligned;
        wr_en     = memwrite && access_ok;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                d_mem[i] <= '0;
            end
        end else if (wr_en) begin
            d_mem[idx] <= write_d;
        end
    end

    always_comb begin
        read_d = '0;
        if (reset && memread && access_ok) begin
            read_d = d_mem[idx];
        end
    end

`ifdef DATA_MEM_ALIGN_CHECK_EN
`ifndef SYNTHESIS
    always @(posedge clock) begin
        if (reset && (memread || memwrite) && !aligned) begin
            $display("data_memory: warning, misaligned access to addr 0x%08h", addr);
        end
    end
`endif
`endif

endmodule

// File: tb/tb_data_memory.sv
// Self-checking bench for data_memory using an expected-value scoreboard queue.
module tb_data_memory;
    import data_mem_pkg::*;

    typedef struct {
        string       name;
        logic [31:0] val;
    } exp_t;

    logic              clock;
    logic              reset;
    logic              memwrite;
    logic              memread;
    logic [31:0]       addr;
    logic [DATA_W-1:0] write_d;
    logic [DATA_W-1:0] read_d;

    exp_t q[$];
    exp_t e;
    int   total;
    int   bad;

    data_memory dut (
        .clock    (clock),
        .reset    (reset),
        .memwrite (memwrite),
        .memread  (memread),
        .addr     (addr),
        .write_d  (write_d),
        .read_d   (read_d)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic int count_nonzero();
        int n = 0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (dut.d_mem[i] !== '0) n++;
        end
        return n;
    endfunction

    function automatic int count_value(input logic [31:0] v);
        int n = 0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (dut.d_mem[i] === v) n++;
        end
        return n;
    endfunction

    task automatic push(input string name, input logic [31:0] val);
        exp_t x;
        x.name = name;
        x.val  = val;
        q.push_back(x);
    endtask

    task automatic write_word(input logic [31:0] a, input logic [31:0] d);
        @(negedge clock);
        addr     = a;
        write_d  = d;
        memwrite = 1'b1;
        memread  = 1'b0;
        @(posedge clock);
        #1;
        memwrite = 1'b0;
    endtask

    task automatic test_reset();
        memread = 1'b1;
        addr    = 32'h0;
        #1;
        push("reset_read_d", 32'h0);
        e = q.pop_front(); total++;
        if (read_d !== e.val) begin
            bad++; $display("FAIL %s got=%h want=%h", e.name, read_d, e.val);
        end
        push("reset_nonzero_words", 32'd0);
        e = q.pop_front(); total++;
        if (count_nonzero() !== int'(e.val)) begin
            bad++; $display("FAIL %s got=%0d want=%0d", e.name, count_nonzero(), e.val);
        end
        memread = 1'b0;
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic test_word0();
        write_word(32'h0, 32'h1111_1111);
        push("w0_dmem", 32'h1111_1111);
        e = q.pop_front(); total++;
        if (dut.d_mem[0] !== e.val) begin
            bad++; $display("FAIL %s got=%h want=%h", e.name, dut.d_mem[0], e.val);
        end
        memread = 1'b1;
        addr    = 32'h0;
        #1;
        push("w0_read", 32'h1111_1111);
        e = q.pop_front(); total++;
        if (read_d !== e.val) begin
            bad++; $display("FAIL %s got=%h want=%h", e.name, read_d, e.val);
        end
        memread = 1'b0;
        #1;
        push("w0_read_gated", 32'h0);
        e = q.pop_front(); total++;
        if (read_d !== e.val) begin
            bad++; $display("FAIL %s got=%h want=%h", e.name, read_d, e.val);
        end
    endtask

    task automatic test_word64();
        write_word(32'h100, 32'h1234_5678);
        push("w64_dmem", 32'h1234_5678);
        e = q.pop_front(); total++;
        if (dut.d_mem[64] !== e.val) begin
            bad++; $display("FAIL %s got=%h want=%h", e.name, dut.d_mem[64], e.val);
        end
        memread = 1'b1;
        addr    = 32'h100;
        #1;
        push("w64_read", 32'h1234_5678);
        e = q.pop_front(); total++;
        if (read_d !== e.val) begin
            bad++; $display("FAIL %s got=%h want=%h", e.name, read_d, e.val);
        end
        // Same word through a non-zero low byte offset.
        addr = 32'h103;
        #1;
`ifdef DATA_MEM_ALIGN_CHECK_EN
        push("w64_read_offset", 32'h0);
`else
        push("w64_read_offset", 32'h1234_5678);
`endif
        e = q.pop_front(); total++;
        if (read_d !== e.val) begin
            bad++; $display("FAIL %s got=%h want=%h", e.name, read_d, e.val);
        end
        memread = 1'b0;
        push("w0_kept", 32'h1111_1111);
        e = q.pop_front(); total++;
        if (dut.d_mem[0] !== e.val) begin
            bad++; $display("FAIL %s got=%h want=%h", e.name, dut.d_mem[0], e.val);
        end
    endtask

    task automatic test_top_word();
        write_word(32'h2FFC, 32'h0BAD_F00D);
        push("top_word_dmem", 32'h0BAD_F00D);
        e = q.pop_front(); total++;
        if (dut.d_mem[DEPTH-1] !== e.val) begin
            bad++; $display("FAIL %s got=%h want=%h", e.name, dut.d_mem[DEPTH-1], e.val);
        end
    endtask

    task automatic test_reset_midrun();
        @(negedge clock);
        #2;
        memread = 1'b1;
        addr    = 32'h100;
        reset   = 1'b0;
        #1;
        push("mid_reset_nonzero_words", 32'd0);
        e = q.pop_front(); total++;
        if (count_nonzero() !== int'(e.val)) begin
            bad++; $display("FAIL %s got=%0d want=%0d", e.name, count_nonzero(), e.val);
        end
        push("mid_reset_read_d", 32'h0);
        e = q.pop_front(); total++;
        if (read_d !== e.val) begin
            bad++; $display("FAIL %s got=%h want=%h", e.name, read_d, e.val);
        end
        // Write attempted across an edge while reset is still low.
        memread  = 1'b0;
        memwrite = 1'b1;
        addr     = 32'h10;
        write_d  = 32'hFFFF_0000;
        @(posedge clock);
        #1;
        memwrite = 1'b0;
        push("reset_blocks_write", 32'h0);
        e = q.pop_front(); total++;
        if (dut.d_mem[4] !== e.val) begin
            bad++; $display("FAIL %s got=%h want=%h", e.name, dut.d_mem[4], e.val);
        end
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic test_simul_rw();
        @(negedge clock);
        addr     = 32'h8;
        write_d  = 32'hA5A5_A5A5;
        memread  = 1'b1;
        memwrite = 1'b1;
        #1;
        push("rw_before_edge", 32'h0);
        e = q.pop_front(); total++;
        if (read_d !== e.val) begin
            bad++; $display("FAIL %s got=%h want=%h", e.name, read_d, e.val);
        end
        @(posedge clock);
        #1;
        memwrite = 1'b0;
        push("rw_after_edge", 32'hA5A5_A5A5);
        e = q.pop_front(); total++;
        if (read_d !== e.val) begin
            bad++; $display("FAIL %s got=%h want=%h", e.name, read_d, e.val);
        end
        memread = 1'b0;
    endtask

    task automatic test_out_of_range();
        write_word(32'h3000, 32'hDEAD_BEEF);
        push("oor_no_write", 32'd0);
        e = q.pop_front(); total++;
        if (count_value(32'hDEAD_BEEF) !== int'(e.val)) begin
            bad++; $display("FAIL %s got=%0d want=%0d", e.name, count_value(32'hDEAD_BEEF), e.val);
        end
        push("oor_word0_untouched", 32'h0);
        e = q.pop_front(); total++;
        if (dut.d_mem[0] !== e.val) begin
            bad++; $display("FAIL %s got=%h want=%h", e.name, dut.d_mem[0], e.val);
        end
        push("oor_word2_kept", 32'hA5A5_A5A5);
        e = q.pop_front(); total++;
        if (dut.d_mem[2] !== e.val) begin
            bad++; $display("FAIL %s got=%h want=%h", e.name, dut.d_mem[2], e.val);
        end
        memread = 1'b1;
        addr    = 32'h3000;
        #1;
        push("oor_read", 32'h0);
        e = q.pop_front(); total++;
        if (read_d !== e.val) begin
            bad++; $display("FAIL %s got=%h want=%h", e.name, read_d, e.val);
        end
        memread = 1'b0;
    endtask

    task automatic test_alignment();
        write_word(32'h5, 32'hCAFE_0005);
`ifdef DATA_MEM_ALIGN_CHECK_EN
        push("align_word1", 32'h0);
`else
        push("align_word1", 32'hCAFE_0005);
`endif
        e = q.pop_front(); total++;
        if (dut.d_mem[1] !== e.val) begin
            bad++; $display("FAIL %s got=%h want=%h", e.name, dut.d_mem[1], e.val);
        end
        memread = 1'b1;
        addr    = 32'h4;
        #1;
`ifdef DATA_MEM_ALIGN_CHECK_EN
        push("align_read_word1", 32'h0);
`else
        push("align_read_word1", 32'hCAFE_0005);
`endif
        e = q.pop_front(); total++;
        if (read_d !== e.val) begin
            bad++; $display("FAIL %s got=%h want=%h", e.name, read_d, e.val);
        end
        memread = 1'b0;
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        reset    = 1'b1;
        memwrite = 1'b0;
        memread  = 1'b0;
        addr     = 32'h0;
        write_d  = 32'h0;
        #3;
        reset = 1'b0;
        test_reset();
        test_word0();
        test_word64();
        test_top_word();
        test_reset_midrun();
        test_simul_rw();
        test_out_of_range();
        test_alignment();
        if (q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_leftover got=%0d want=0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
